mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/mem_arb_pick.sv | 57 +++++
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg -- shared types and default widths for the memory port arbiter.
//
// Contents:
//   DEF_ADDR_W / DEF_DATA_W / DEF_STRB_W : default parameter values
//   state_t  : transaction FSM states (IDLE, REQ, RESP)
//   owner_t  : which requester owns the current transaction (OWN_I fetch, OWN_D data)
//   other_owner() : returns the opposite requester, used by the round-robin pointer
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_STRB_W = DEF_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_I) ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick -- grant selection between the fetch and data requesters.
//
// Ports:
//   clk, rst   : clock / synchronous active-high reset (present only when the
//                round-robin pointer exists, i.e. MEM_ARB_RR_EN is defined)
//   pick_en    : arbiter is free to grant this cycle
//   i_req      : fetch request
//   d_req      : data request
//   gnt_any    : a grant is issued this cycle
//   gnt_owner  : which requester receives it (valid when gnt_any)
//
// Build option MEM_ARB_RR_EN: when defined, a tie is resolved in favour of the
// requester that was not granted last (pointer starts favouring fetch). When
// undefined, data always wins a tie.
module mem_arb_pick
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic   clk,
  input  logic   rst,
`endif
  input  logic   pick_en,
  input  logic   i_req,
  input  logic   d_req,
  output logic   gnt_any,
  output owner_t gnt_owner
);

`ifdef MEM_ARB_RR_EN
  // Requester that wins the next tie.
  owner_t prio_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_reg <= OWN_I;
    end else if (gnt_any) begin
      prio_reg <= other_owner(gnt_owner);
    end
  end

  always_comb begin
    gnt_any   = pick_en && (i_req || d_req);
    gnt_owner = OWN_I;
    if (i_req && d_req) begin
      gnt_owner = prio_reg;
    end else if (d_req) begin
      gnt_owner = OWN_D;
    end
  end
`else
  always_comb begin
    gnt_any   = pick_en && (i_req || d_req);
    gnt_owner = d_req ? OWN_D : OWN_I;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter -- shares one memory request/response port between a fetch
// (read-only) requester and a data (read/write) requester, with at most one
// transaction outstanding.
//
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   i_req/i_addr -> i_gnt            : fetch request, one-cycle grant pulse
//   i_rvalid/i_rdata                 : fetch response
//   d_req/d_we/d_addr/d_wdata/d_wstrb -> d_gnt : data request, grant pulse
//   d_rvalid/d_rdata                 : data response (read data or write ack)
//   mem_valid/mem_ready              : memory request handshake
//   mem_we/mem_addr/mem_wdata/mem_wstrb : memory request payload
//   mem_rvalid/mem_rdata             : memory response, one per accepted request
//
// Flow: IDLE grants (combinationally, same cycle as the request) and latches
// the payload; REQ drives mem_valid until mem_ready; RESP waits for mem_rvalid
// and routes it to the owner. Build option MEM_ARB_RR_EN selects round-robin
// tie-breaking inside mem_arb_pick; otherwise data beats fetch.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [STRB_W-1:0] d_wstrb,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t              state_reg, state_next;
  owner_t              owner_reg;
  logic                we_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [STRB_W-1:0]   wstrb_reg;

  logic                pick_en;
  logic                gnt_any;
  owner_t              gnt_owner;
  logic                resp_hit;

  // Grants are only offered in IDLE and never while reset is held, so a
  // request present during reset cannot produce a grant pulse.
  assign pick_en = (state_reg == IDLE) && !rst;

  mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .clk       (clk),
    .rst       (rst),
`endif
    .pick_en   (pick_en),
    .i_req     (i_req),
    .d_req     (d_req),
    .gnt_any   (gnt_any),
    .gnt_owner (gnt_owner)
  );

  assign i_gnt = gnt_any && (gnt_owner == OWN_I);
  assign d_gnt = gnt_any && (gnt_owner == OWN_D);

  // Next-state logic. mem_rvalid outside RESP is simply not looked at, which
  // also discards a late response belonging to a transaction killed by reset.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: if (gnt_any)    state_next = REQ;
      REQ:  if (mem_ready)  state_next = RESP;
      RESP: if (mem_rvalid) state_next = IDLE;
      default:              state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      owner_reg <= OWN_I;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wstrb_reg <= '0;
    end else begin
      state_reg <= state_next;
      // Payload is captured only at grant, keeping it stable through REQ.
      if (gnt_any) begin
        owner_reg <= gnt_owner;
        if (gnt_owner == OWN_D) begin
          we_reg    <= d_we;
          addr_reg  <= d_addr;
          wdata_reg <= d_we ? d_wdata : '0;
          wstrb_reg <= d_we ? d_wstrb : {STRB_W{1'b1}};
        end else begin
          we_reg    <= 1'b0;
          addr_reg  <= i_addr;
          wdata_reg <= '0;
          wstrb_reg <= {STRB_W{1'b1}};
        end
      end
    end
  end

  assign mem_valid = (state_reg == REQ);
  assign mem_we    = we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign mem_wstrb = wstrb_reg;

  // Response routing is combinational from mem_rvalid; rdata is forced to zero
  // outside the response cycle so idle outputs are quiet.
  assign resp_hit = (state_reg == RESP) && mem_rvalid && !rst;
  assign i_rvalid = resp_hit && (owner_reg == OWN_I);
  assign d_rvalid = resp_hit && (owner_reg == OWN_D);
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter -- directed self-checking bench for mem_port_arbiter.
// Expected responses are pushed to a scoreboard queue when the bench drives
// mem_rvalid and popped by a monitor when the DUT raises i_rvalid/d_rvalid.
// Define MEM_ARB_RR_EN for both bench and RTL to exercise round-robin ties.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
`ifdef MEM_ARB_RR_EN
  localparam bit RR_BUILD = 1'b1;
`else
  localparam bit RR_BUILD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [STRB_W-1:0] d_wstrb;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic              own_d;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Response monitor: every rvalid must match the oldest expected response.
  always @(negedge clk) begin
    if (i_rvalid || d_rvalid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", {62'd0, i_rvalid, d_rvalid}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("resp: %s data=0x%08h", e.own_d ? "D" : "I", e.own_d ? d_rdata : i_rdata);
        chk("rvalid_route", {62'd0, i_rvalid, d_rvalid}, e.own_d ? 64'd1 : 64'd2);
        chk("rdata", {32'd0, (e.own_d ? d_rdata : i_rdata)}, {32'd0, e.data});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one memory response for the current cycle and expect it routed.
  task automatic respond(input logic own_d, input logic [DATA_W-1:0] data);
    exp_t e;
    e.own_d = own_d;
    e.data  = data;
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    sb.push_back(e);
    @(negedge clk);
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    chk("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b1; i_addr = 32'h44; d_req = 1'b1; d_we = 1'b1;
    d_addr = 32'h88; d_wdata = 32'h1111_2222; d_wstrb = 4'hF;
    mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset with both requests asserted: nothing may be granted.
    tick(); tick();
    @(negedge clk);
    chk("rst_i_gnt", {63'd0, i_gnt}, 64'd0);
    chk("rst_d_gnt", {63'd0, d_gnt}, 64'd0);
    chk("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
    chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
    chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    chk("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
    chk("rst_mem_wstrb", {60'd0, mem_wstrb}, 64'd0);
    chk("rst_rdata", {i_rdata, d_rdata}, 64'd0);
    tick();
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;

    // Fetch-only read.
    tick();
    i_req = 1'b1; i_addr = 32'h100; mem_ready = 1'b1;
    @(negedge clk);
    $display("txn: fetch read 0x100");
    chk("f_i_gnt", {63'd0, i_gnt}, 64'd1);
    chk("f_d_gnt", {63'd0, d_gnt}, 64'd0);
    chk("f_valid_n", {63'd0, mem_valid}, 64'd0);
    tick();
    i_req = 1'b0;
    @(negedge clk);
    chk("f_valid_n1", {63'd0, mem_valid}, 64'd1);
    chk("f_addr", {32'd0, mem_addr}, 64'h100);
    chk("f_we", {63'd0, mem_we}, 64'd0);
    chk("f_wstrb", {60'd0, mem_wstrb}, 64'hF);
    tick();
    @(negedge clk);
    chk("f_valid_resp", {63'd0, mem_valid}, 64'd0);
    tick();
    respond(1'b0, 32'h0000_0013);

    // Simultaneous requests: data first, fetch right after the response.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; i_req = 1'b1; i_addr = 32'h80;
    @(negedge clk);
    $display("txn: tie, data read 0x40 vs fetch 0x80");
    chk("tie_d_gnt", {63'd0, d_gnt}, 64'd1);
    chk("tie_i_gnt", {63'd0, i_gnt}, 64'd0);
    tick();
    d_req = 1'b0;
    @(negedge clk);
    chk("tie_valid", {63'd0, mem_valid}, 64'd1);
    chk("tie_addr", {32'd0, mem_addr}, 64'h40);
    chk("tie_rd_wstrb", {60'd0, mem_wstrb}, 64'hF);
    chk("tie_busy_i_gnt", {63'd0, i_gnt}, 64'd0);
    tick();
    @(negedge clk);
    chk("tie_resp_i_gnt", {63'd0, i_gnt}, 64'd0);
    tick();
    respond(1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("tie_next_i_gnt", {63'd0, i_gnt}, 64'd1);
    tick();
    i_req = 1'b0;
    @(negedge clk);
    chk("tie_f_addr", {32'd0, mem_addr}, 64'h80);
    tick();
    respond(1'b0, 32'h0000_1234);

    // Write with mem_ready low for 3 cycles; stray mem_rvalid in REQ and a
    // fetch request dropped before it could be granted.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hCAFE_F00D; d_wstrb = 4'b0011;
    mem_ready = 1'b0;
    @(negedge clk);
    $display("txn: data write 0x2000 strb 0011, ready stalled");
    chk("w_d_gnt", {63'd0, d_gnt}, 64'd1);
    tick();
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0; i_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) i_req = 1'b0;
      mem_ready  = (k == 3);
      mem_rvalid = (k == 1);
      mem_rdata  = (k == 1) ? 32'hBAD0_BAD0 : 32'h0;
      @(negedge clk);
      chk("w_valid", {63'd0, mem_valid}, 64'd1);
      chk("w_payload", {mem_addr, mem_wdata}, {32'h2000, 32'hCAFE_F00D});
      chk("w_we_strb", {59'd0, mem_we, mem_wstrb}, {59'd0, 1'b1, 4'b0011});
      chk("w_busy_i_gnt", {63'd0, i_gnt}, 64'd0);
      tick();
    end
    mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    chk("w_valid_done", {63'd0, mem_valid}, 64'd0);
    tick();
    respond(1'b1, 32'h0000_5A5A);
    @(negedge clk);
    chk("drop_i_gnt", {63'd0, i_gnt}, 64'd0);
    tick();
    @(negedge clk);
    chk("drop_valid", {63'd0, mem_valid}, 64'd0);

    // Reset during RESP, then a stale response.
    tick();
    mem_ready = 1'b1; i_req = 1'b1; i_addr = 32'h300;
    @(negedge clk);
    $display("txn: fetch 0x300 aborted by reset");
    chk("a_i_gnt", {63'd0, i_gnt}, 64'd1);
    tick();
    i_req = 1'b0;
    @(negedge clk);
    chk("a_valid", {63'd0, mem_valid}, 64'd1);
    tick();
    rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDDDD_DDDD;
    @(negedge clk);
    chk("a_rst_rvalid", {62'd0, i_rvalid, d_rvalid}, 64'd0);
    tick();
    rst = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    chk("a_valid_post", {63'd0, mem_valid}, 64'd0);
    tick();
    mem_rvalid = 1'b1;
    @(negedge clk);
    chk("a_stale_rvalid", {62'd0, i_rvalid, d_rvalid}, 64'd0);
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    @(negedge clk);
    $display("txn: data read 0x400 after abort");
    chk("a_next_d_gnt", {63'd0, d_gnt}, 64'd1);
    tick();
    d_req = 1'b0;
    @(negedge clk);
    chk("a_next_addr", {32'd0, mem_addr}, 64'h400);
    tick();
    respond(1'b1, 32'h0000_0077);

    // Both requesters held for 6 transactions: round robin alternates starting
    // with fetch after reset; fixed priority always picks data.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_req = 1'b1; i_addr = 32'hA00; d_req = 1'b1; d_we = 1'b0; d_addr = 32'hB00;
    for (int t = 0; t < 6; t++) begin
      logic exp_d;
      exp_d = RR_BUILD ? (t % 2 == 1) : 1'b1;
      @(negedge clk);
      $display("txn: held tie #%0d expect %s", t, exp_d ? "D" : "I");
      chk("held_gnt", {62'd0, i_gnt, d_gnt}, exp_d ? 64'd1 : 64'd2);
      tick();
      @(negedge clk);
      chk("held_addr", {32'd0, mem_addr}, exp_d ? 64'hB00 : 64'hA00);
      tick();
      respond(exp_d, 32'h100 + 32'(t));
    end
    i_req = 1'b0; d_req = 1'b0;

    tick();
    chk("sb_empty_end", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
